ram_readback_unit: RTL and testbench
====================================

// Module: ram_readback_unit
// PURPOSE
//  Bus initiator that reads a block of the SPARC MPU RAM back out through the MOV/MFC
//  memory handshake: the reader end of the RAM preload path. It dumps COUNT items
//  (byte/halfword/word) from START_ADDR onto a valid/ready stream for self-check and
//  debug. It sits beside the control unit's memory port; the datapath muxes it in when Busy=1.
// PARAMETERS
//  ADDR_W   9   RAM byte-address width (512 bytes)
//  CNT_W    8   width of item count
//  TMO      15  max cycles to wait for MFC before TmoErr
// PORTS
//  Clk        in   1       clock, rising edge
//  Clr        in   1       synchronous reset, active-high
//  Start      in   1       one-cycle request; ignored unless idle
//  StartAddr  in   ADDR_W  first byte address
//  Count      in   CNT_W   number of items to read
//  Type       in   2       00 byte, 01 halfword, 10 word, 11 illegal
//  MFC        in   1       RAM memory-function-complete
//  RamData    in   32      RAM read data, valid while MFC=1
//  MOV        out  1       memory operation valid, to RAM
//  RW         out  1       1=read; held 1 whenever MOV=1
//  MemType    out  2       access size to RAM (=latched Type)
//  MemAddr    out  ADDR_W  current byte address
//  DumpData   out  32      item, zero-extended
//  DumpValid  out  1       DumpData valid
//  DumpReady  in   1       sink accepts item when DumpValid&DumpReady
//  Busy       out  1       high from accepted Start until Done
//  Done       out  1       one-cycle pulse at end (normal or error)
//  AlignErr   out  1       sticky until next Start: misaligned addr or Type=11
//  TmoErr     out  1       sticky until next Start: MFC timeout
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (MOV, RW, MemType, MemAddr, DumpData, flags).
//  FSM: IDLE -> CHECK -> REQ -> WAIT -> OUT -> (REQ | FIN) -> IDLE.
//  IDLE: on Start latch StartAddr/Count/Type, clear flags, Busy=1, go CHECK.
//  CHECK (1 cycle): Type=11, or Type=01 with addr[0]=1, or Type=10 with addr[1:0]!=0
//   -> set AlignErr, go FIN; Count=0 -> go FIN; else go REQ.
//  REQ: drive MOV=1, RW=1, MemAddr, MemType; go WAIT next cycle (MOV held high in WAIT).
//  WAIT: timer counts from 0; MFC=1 -> capture RamData masked to size (byte [7:0],
//   half [15:0]), drop MOV, go OUT. Timer reaches TMO without MFC -> TmoErr=1, MOV=0, FIN.
//  OUT: DumpValid=1, DumpData stable until handshake; on DumpReady: remaining-=1,
//   addr += 1/2/4 (mod 2^ADDR_W, wrap silently); remaining=0 -> FIN, else REQ.
//  FIN: Done=1 for one cycle, Busy=0 next cycle, return IDLE.
//  Min latency per item: REQ 1 + WAIT >=1 + OUT >=1 = 3 cycles.
//  Start while busy: ignored. DumpReady while DumpValid=0: no effect.
//  MFC outside WAIT: ignored. Clr mid-transfer: immediate return to IDLE, MOV drops
//   the same edge; no Done pulse.
// STRUCTURE
//  Shared package/header: memory size codes (MT_BYTE/MT_HALF/MT_WORD) and RW_READ,
//   shared with the control unit and RAM.
//  One sub-module: ram_rb_timer (load/clear, count, expired at TMO), reusable by CU.
//  Rest single module: FSM, address/count regs, data-capture reg.
// TESTING
//  Word dump: RAM[0..7]=00..07, Start addr=0 Count=2 Type=10, RAM MFC after 2 cycles
//   -> items 00010203, 04050607; MemAddr 0 then 4; one Done; no flags.
//  Byte dump w/ backpressure: addr=5 Count=3 Type=00, DumpReady low 4 cycles each ->
//   items 05,06,07 each held stable while stalled; MOV low during stalls.
//  Misalign: addr=3 Type=01 -> AlignErr=1, Done within 3 cycles, MOV never asserted.
//  Timeout: MFC tied 0 -> MOV high exactly TMO cycles in WAIT, then TmoErr=1 and Done.
//  Wrap: addr=0x1FC Count=2 Type=10 -> MemAddr 0x1FC then 0x000.
//  Reset mid-WAIT: Clr=1 -> next edge MOV=0, Busy=0, DumpValid=0; Count=0 Start -> Done
//   only, no MOV.

Source files
------------

// File: rtl/ram_readback_unit_pkg.sv
// Shared memory-access encodings for the RAM readback path, plus small helpers
// for size decoding used by the readback FSM.
package ram_readback_unit_pkg;

  localparam logic [1:0] MT_BYTE = 2'b00;
  localparam logic [1:0] MT_HALF = 2'b01;
  localparam logic [1:0] MT_WORD = 2'b10;
  localparam logic [1:0] MT_ILL  = 2'b11;
  localparam logic       RW_READ = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4,
    S_FIN   = 3'd5
  } rb_state_e;

  function automatic logic is_misaligned(input logic [1:0] mt, input logic [1:0] a);
    logic bad;
    case (mt)
      MT_BYTE: bad = 1'b0;
      MT_HALF: bad = a[0];
      MT_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] mask_data(input logic [1:0] mt, input logic [31:0] d);
    logic [31:0] r;
    case (mt)
      MT_BYTE: r = {24'h000000, d[7:0]};
      MT_HALF: r = {16'h0000, d[15:0]};
      MT_WORD: r = d;
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] step_bytes(input logic [1:0] mt);
    logic [2:0] s;
    case (mt)
      MT_BYTE: s = 3'd1;
      MT_HALF: s = 3'd2;
      MT_WORD: s = 3'd4;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ram_rb_timer.sv
// Wait-cycle timer: cleared on load, counts while enabled, and flags the cycle
// in which the LIMIT-th enabled cycle is being spent.
module ram_rb_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         exp_q, exp_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
    exp_d = (cnt_d == W'(LIMIT - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/ram_readback_unit.sv
// Reads COUNT items back out of the MPU RAM over the MOV/MFC handshake and
// presents each one, zero-extended, on a valid/ready dump stream.
module ram_readback_unit
  import ram_readback_unit_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8,
  parameter int TMO    = 15
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [CNT_W-1:0]  Count,
  input  logic [1:0]        Type,
  input  logic              MFC,
  input  logic [31:0]       RamData,
  output logic              MOV,
  output logic              RW,
  output logic [1:0]        MemType,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       DumpData,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done,
  output logic              AlignErr,
  output logic              TmoErr
);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [1:0]        type_q, type_d;
  logic [31:0]       data_q, data_d;
  logic              align_q, align_d;
  logic              tmo_q, tmo_d;
  logic              mov_q, rw_q, valid_q, busy_q, done_q;
  logic              tmr_clr_s, tmr_en_s, tmr_exp_s;

  ram_rb_timer #(.LIMIT(TMO)) u_timer (
    .clk_i     (Clk),
    .rst_i     (Clr),
    .clr_i     (tmr_clr_s),
    .en_i      (tmr_en_s),
    .expired_o (tmr_exp_s)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    type_d    = type_q;
    data_d    = data_q;
    align_d   = align_q;
    tmo_d     = tmo_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          addr_d  = StartAddr;
          rem_d   = Count;
          type_d  = Type;
          align_d = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (is_misaligned(type_q, addr_q[1:0])) begin
          align_d = 1'b1;
          state_d = S_FIN;
        end else if (rem_q == {CNT_W{1'b0}}) begin
          state_d = S_FIN;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        tmr_clr_s = 1'b1;
        state_d   = S_WAIT;
      end
      // MFC wins over a timeout landing in the same cycle.
      S_WAIT: begin
        if (MFC) begin
          data_d  = mask_data(type_q, RamData);
          state_d = S_OUT;
        end else if (tmr_exp_s) begin
          tmo_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      S_OUT: begin
        if (DumpReady) begin
          rem_d  = rem_q - CNT_W'(1'b1);
          addr_d = addr_q + ADDR_W'(step_bytes(type_q));
          if (rem_q == CNT_W'(1'b1)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      rem_q   <= {CNT_W{1'b0}};
      type_q  <= 2'b00;
      data_q  <= 32'h00000000;
      align_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      type_q  <= type_d;
      data_q  <= data_d;
      align_q <= align_d;
      tmo_q   <= tmo_d;
    end
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      mov_q   <= 1'b0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mov_q   <= (state_d == S_REQ) || (state_d == S_WAIT);
      rw_q    <= ((state_d == S_REQ) || (state_d == S_WAIT)) ? RW_READ : 1'b0;
      valid_q <= (state_d == S_OUT);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_FIN);
    end
  end

  assign MOV       = mov_q;
  assign RW        = rw_q;
  assign MemType   = type_q;
  assign MemAddr   = addr_q;
  assign DumpData  = data_q;
  assign DumpValid = valid_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign AlignErr  = align_q;
  assign TmoErr    = tmo_q;

endmodule

// File: tb/tb_ram_readback_unit.sv
// Directed bench for ram_readback_unit: a cycle-stepped RAM responder and dump
// sink, with each scenario task checking its own hand-computed results.
module tb_ram_readback_unit;

  localparam int TMO = 15;

  logic        Clk = 1'b0;
  logic        Clr, Start, MFC, DumpReady;
  logic [8:0]  StartAddr;
  logic [7:0]  Count;
  logic [1:0]  Type;
  logic [31:0] RamData;
  logic        MOV, RW, DumpValid, Busy, Done, AlignErr, TmoErr;
  logic [1:0]  MemType;
  logic [8:0]  MemAddr;
  logic [31:0] DumpData;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:511];
  int          mfc_delay, mov_age, stall_len, stall_cnt;
  bit          mfc_never, prev_mov;
  logic [31:0] items[$];
  logic [8:0]  addrs[$];
  int          done_cnt, mov_total, unstable, mov_in_out, stall_total;

  always #5 Clk = ~Clk;

  ram_readback_unit dut (
    .Clk(Clk), .Clr(Clr), .Start(Start), .StartAddr(StartAddr), .Count(Count),
    .Type(Type), .MFC(MFC), .RamData(RamData), .MOV(MOV), .RW(RW),
    .MemType(MemType), .MemAddr(MemAddr), .DumpData(DumpData),
    .DumpValid(DumpValid), .DumpReady(DumpReady), .Busy(Busy), .Done(Done),
    .AlignErr(AlignErr), .TmoErr(TmoErr)
  );

  // Big-endian RAM; narrow reads carry junk in the upper lanes.
  function automatic logic [31:0] ram_read(input logic [8:0] a, input logic [1:0] mt);
    logic [8:0] a1, a2, a3;
    a1 = a + 9'd1; a2 = a + 9'd2; a3 = a + 9'd3;
    case (mt)
      2'b00:   return {24'hA5A5A5, mem[a]};
      2'b01:   return {16'hA5A5, mem[a], mem[a1]};
      default: return {mem[a], mem[a1], mem[a2], mem[a3]};
    endcase
  endfunction

  task automatic cycle();
    logic        pv, pr;
    logic [31:0] pd;
    pv = DumpValid; pr = DumpReady; pd = DumpData;
    @(posedge Clk); #1;
    if (pv === 1'b1 && pr === 1'b1) items.push_back(pd);
    if (pv === 1'b1 && pr === 1'b0) begin
      stall_total++;
      if (DumpValid !== 1'b1 || DumpData !== pd) unstable++;
    end
    if (DumpValid === 1'b1 && MOV === 1'b1) mov_in_out++;
    if (MOV === 1'b1 && !prev_mov) addrs.push_back(MemAddr);
    prev_mov = (MOV === 1'b1);
    if (MOV === 1'b1) begin mov_total++; mov_age++; end else mov_age = 0;
    if (Done === 1'b1) done_cnt++;
    MFC = (MOV === 1'b1) && !mfc_never && (mov_age > mfc_delay);
    RamData = MFC ? ram_read(MemAddr, MemType) : 32'hDEADBEEF;
    if (DumpValid === 1'b1) begin
      if (stall_cnt < stall_len) begin DumpReady = 1'b0; stall_cnt++; end
      else DumpReady = 1'b1;
    end else begin
      DumpReady = 1'b1; stall_cnt = 0;
    end
  endtask

  task automatic start_op(input logic [8:0] a, input logic [7:0] n, input logic [1:0] t);
    items.delete(); addrs.delete();
    done_cnt = 0; mov_total = 0; unstable = 0; mov_in_out = 0; stall_total = 0;
    StartAddr = a; Count = n; Type = t; Start = 1'b1;
    cycle();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      cycle();
      if (Done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    cycle(); cycle();
    checks++; if ({MOV, RW, DumpValid, Busy, Done} !== 5'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {MOV, RW, DumpValid, Busy, Done}); end
    checks++; if ({AlignErr, TmoErr} !== 2'b0) begin errors++;
      $display("FAIL reset_flags: got %b expected 00", {AlignErr, TmoErr}); end
    checks++; if (MemAddr !== 9'h000 || MemType !== 2'b00) begin errors++;
      $display("FAIL reset_mem: got addr %h type %b expected 000/00", MemAddr, MemType); end
    checks++; if (DumpData !== 32'h0) begin errors++;
      $display("FAIL reset_data: got %h expected 00000000", DumpData); end
    Clr = 1'b0;
    cycle();
  endtask

  task automatic test_word_dump();
    bit got;
    mfc_delay = 2; stall_len = 0;
    start_op(9'h000, 8'd2, 2'b10);
    wait_done(40, got);
    checks++; if (!got) begin errors++; $display("FAIL word_done: got no Done expected Done"); end
    checks++; if (items.size() !== 2) begin errors++;
      $display("FAIL word_count: got %0d expected 2", items.size()); end
    else begin
      checks++; if (items[0] !== 32'h00010203) begin errors++;
        $display("FAIL word_item0: got %h expected 00010203", items[0]); end
      checks++; if (items[1] !== 32'h04050607) begin errors++;
        $display("FAIL word_item1: got %h expected 04050607", items[1]); end
    end
    checks++; if (addrs.size() !== 2 || addrs[0] !== 9'h000 || addrs[1] !== 9'h004) begin errors++;
      $display("FAIL word_addrs: got %p expected 0,4", addrs); end
    cycle(); cycle(); cycle();
    checks++; if (done_cnt !== 1 || Busy !== 1'b0) begin errors++;
      $display("FAIL word_end: got done %0d busy %b expected 1/0", done_cnt, Busy); end
    checks++; if ({AlignErr, TmoErr} !== 2'b00) begin errors++;
      $display("FAIL word_flags: got %b expected 00", {AlignErr, TmoErr}); end
  endtask

  task automatic test_byte_backpressure();
    bit got;
    mfc_delay = 1; stall_len = 4;
    start_op(9'h005, 8'd3, 2'b00);
    wait_done(80, got);
    checks++; if (!got) begin errors++; $display("FAIL byte_done: got no Done expected Done"); end
    checks++; if (items.size() !== 3) begin errors++;
      $display("FAIL byte_count: got %0d expected 3", items.size()); end
    else begin
      checks++; if (items[0] !== 32'h05 || items[1] !== 32'h06 || items[2] !== 32'h07) begin errors++;
        $display("FAIL byte_items: got %h %h %h expected 05 06 07", items[0], items[1], items[2]); end
    end
    checks++; if (stall_total !== 12) begin errors++;
      $display("FAIL byte_stalls: got %0d expected 12", stall_total); end
    checks++; if (unstable !== 0) begin errors++;
      $display("FAIL byte_stable: got %0d changes expected 0", unstable); end
    checks++; if (mov_in_out !== 0) begin errors++;
      $display("FAIL byte_mov_stall: got %0d expected 0", mov_in_out); end
    stall_len = 0;
    cycle();
  endtask

  task automatic test_half_dump();
    bit got;
    mfc_delay = 1;
    start_op(9'h002, 8'd2, 2'b01);
    wait_done(40, got);
    checks++; if (items.size() !== 2) begin errors++;
      $display("FAIL half_count: got %0d expected 2", items.size()); end
    else begin
      checks++; if (items[0] !== 32'h00000203 || items[1] !== 32'h00000405) begin errors++;
        $display("FAIL half_items: got %h %h expected 00000203 00000405", items[0], items[1]); end
    end
    checks++; if (addrs.size() !== 2 || addrs[0] !== 9'h002 || addrs[1] !== 9'h004) begin errors++;
      $display("FAIL half_addrs: got %p expected 2,4", addrs); end
    cycle();
  endtask

  task automatic test_misalign();
    bit got;
    logic [8:0] av [3];
    logic [1:0] tv [3];
    av[0] = 9'h003; tv[0] = 2'b01;
    av[1] = 9'h002; tv[1] = 2'b10;
    av[2] = 9'h000; tv[2] = 2'b11;
    for (int k = 0; k < 3; k++) begin
      start_op(av[k], 8'd4, tv[k]);
      wait_done(2, got);
      checks++; if (!got) begin errors++;
        $display("FAIL misalign_done%0d: got no Done expected Done within 3 cycles", k); end
      checks++; if (AlignErr !== 1'b1 || TmoErr !== 1'b0) begin errors++;
        $display("FAIL misalign_flag%0d: got %b%b expected 10", k, AlignErr, TmoErr); end
      cycle(); cycle();
      checks++; if (mov_total !== 0 || AlignErr !== 1'b1) begin errors++;
        $display("FAIL misalign_mov%0d: got mov %0d sticky %b expected 0/1", k, mov_total, AlignErr); end
    end
  endtask

  task automatic test_timeout();
    bit got;
    mfc_never = 1'b1;
    start_op(9'h008, 8'd1, 2'b10);
    checks++; if (AlignErr !== 1'b0) begin errors++;
      $display("FAIL tmo_clear_align: got %b expected 0", AlignErr); end
    wait_done(60, got);
    checks++; if (!got) begin errors++; $display("FAIL tmo_done: got no Done expected Done"); end
    checks++; if (mov_total !== TMO + 1) begin errors++;
      $display("FAIL tmo_mov_cycles: got %0d expected %0d", mov_total, TMO + 1); end
    checks++; if (TmoErr !== 1'b1 || items.size() !== 0) begin errors++;
      $display("FAIL tmo_flag: got %b items %0d expected 1/0", TmoErr, items.size()); end
    mfc_never = 1'b0;
    cycle();
  endtask

  task automatic test_wrap();
    bit got;
    mfc_delay = 1;
    start_op(9'h1FC, 8'd2, 2'b10);
    checks++; if (TmoErr !== 1'b0) begin errors++;
      $display("FAIL wrap_clear_tmo: got %b expected 0", TmoErr); end
    wait_done(40, got);
    checks++; if (addrs.size() !== 2 || addrs[0] !== 9'h1FC || addrs[1] !== 9'h000) begin errors++;
      $display("FAIL wrap_addrs: got %p expected 1fc,000", addrs); end
    checks++; if (items.size() !== 2 || items[0] !== 32'hFCFDFEFF || items[1] !== 32'h00010203) begin errors++;
      $display("FAIL wrap_items: got %p expected fcfdfeff,00010203", items); end
    cycle();
  endtask

  task automatic test_start_ignored();
    bit got;
    start_op(9'h000, 8'd1, 2'b10);
    cycle();
    StartAddr = 9'h010; Count = 8'd5; Type = 2'b00; Start = 1'b1;
    cycle();
    Start = 1'b0;
    wait_done(40, got);
    cycle(); cycle();
    checks++; if (items.size() !== 1 || items[0] !== 32'h00010203) begin errors++;
      $display("FAIL busy_start_items: got %p expected 00010203", items); end
    checks++; if (addrs.size() !== 1 || done_cnt !== 1 || Busy !== 1'b0) begin errors++;
      $display("FAIL busy_start_ops: got %0d reqs %0d dones busy %b expected 1/1/0",
               addrs.size(), done_cnt, Busy); end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    mfc_never = 1'b1;
    start_op(9'h000, 8'd1, 2'b10);
    cycle(); cycle(); cycle();
    checks++; if (MOV !== 1'b1) begin errors++;
      $display("FAIL midrst_pre: got MOV %b expected 1", MOV); end
    Clr = 1'b1;
    cycle();
    checks++; if ({MOV, Busy, DumpValid} !== 3'b000) begin errors++;
      $display("FAIL midrst_outputs: got %b expected 000", {MOV, Busy, DumpValid}); end
    Clr = 1'b0; mfc_never = 1'b0;
    cycle(); cycle(); cycle();
    checks++; if (done_cnt !== 0) begin errors++;
      $display("FAIL midrst_nodone: got %0d expected 0", done_cnt); end
    start_op(9'h000, 8'd0, 2'b10);
    wait_done(4, got);
    cycle();
    checks++; if (!got || done_cnt !== 1 || mov_total !== 0) begin errors++;
      $display("FAIL zero_count: got done %0d mov %0d expected 1/0", done_cnt, mov_total); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = i[7:0];
    Clr = 1'b1; Start = 1'b0; MFC = 1'b0; DumpReady = 1'b1; RamData = 32'h0;
    StartAddr = 9'h000; Count = 8'd0; Type = 2'b00;
    mfc_delay = 2; mfc_never = 1'b0; mov_age = 0; stall_len = 0; stall_cnt = 0;
    prev_mov = 1'b0;
    test_reset();
    test_word_dump();
    test_byte_backpressure();
    test_half_dump();
    test_misalign();
    test_timeout();
    test_wrap();
    test_start_ignored();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
